// File: rtl/exec_seq_pkg.sv
// Shared opcodes, FSM state encoding and instruction field helpers for the
// execute sequencer.
package exec_seq_pkg;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ_RS = 2'd1,
    ST_READ_RD = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS_MSB  = 3;
  localparam int RS_LSB  = 2;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  function automatic logic [1:0] f_opcode(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [1:0] f_rd(input logic [7:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [1:0] f_rs(input logic [7:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [3:0] f_imm(input logic [7:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction handshake and register-file port bundle of the execute sequencer.
// master = sequencer side, slave = producer / register-file side.
interface exec_sequencer_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [7:0]            instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [1:0]            rf_read_address;
  logic [DATA_WIDTH-1:0] rf_read_data;
  logic [1:0]            rf_write_address;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic                  rf_write_enable;
  logic                  done;
  logic                  flag_zero;
  logic                  flag_carry;

  modport master (
    input  instr, instr_valid, rf_read_data,
    output instr_ready, rf_read_address, rf_write_address, rf_write_data,
           rf_write_enable, done, flag_zero, flag_carry
  );

  modport slave (
    output instr, instr_valid, rf_read_data,
    input  instr_ready, rf_read_address, rf_write_address, rf_write_data,
           rf_write_enable, done, flag_zero, flag_carry
  );
endinterface

// File: rtl/exec_seq_alu.sv
// Combinational ALU of the execute sequencer: LDI/MOV/ADD/SUB with carry
// (borrow for SUB) and zero outputs.
module exec_seq_alu
  import exec_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]            i_opcode,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  input  logic [3:0]            i_imm4,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_zero
);
  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;

  // The extra top bit of the difference is the borrow (set when a < b).
  assign w_sum  = {1'b0, i_op_a} + {1'b0, i_op_b};
  assign w_diff = {1'b0, i_op_a} - {1'b0, i_op_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_opcode)
      OP_LDI:  o_result = DATA_WIDTH'(i_imm4);
      OP_MOV:  o_result = i_op_b;
      OP_ADD:  {o_carry, o_result} = w_sum;
      OP_SUB:  {o_carry, o_result} = w_diff;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);
endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: walks operands through the single register
// file read port and issues one write-back per instruction. Optional flags: EXEC_SEQ_FLAGS_EN.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  exec_sequencer_if.master bus
);
  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_instr;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [1:0]            r_rd_addr;
  logic [1:0]            r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic [7:0]            w_cur_instr;
  logic [1:0]            w_opcode;
  logic [DATA_WIDTH-1:0] w_alu_a;
  logic [DATA_WIDTH-1:0] w_alu_b;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_carry;
  logic                  w_zero;

  // Operands come straight from the read port in the cycle they are fetched,
  // so the result is ready on the edge entering WRITE; in WRITE itself the
  // latched copies reproduce the same result for the flag update.
  assign w_cur_instr = (r_state == ST_IDLE)    ? bus.instr        : r_instr;
  assign w_opcode    = f_opcode(w_cur_instr);
  assign w_alu_a     = (r_state == ST_READ_RD) ? bus.rf_read_data : r_op_a;
  assign w_alu_b     = (r_state == ST_READ_RS) ? bus.rf_read_data : r_op_b;

  exec_seq_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_opcode (w_opcode),
    .i_op_a   (w_alu_a),
    .i_op_b   (w_alu_b),
    .i_imm4   (f_imm(w_cur_instr)),
    .o_result (w_result),
    .o_carry  (w_carry),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next        = r_state;
    bus.instr_ready     = 1'b0;
    bus.rf_write_enable = 1'b0;
    bus.done            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid)
          w_state_next = (w_opcode == OP_LDI) ? ST_WRITE : ST_READ_RS;
      end
      ST_READ_RS: w_state_next = (w_opcode == OP_MOV) ? ST_WRITE : ST_READ_RD;
      ST_READ_RD: w_state_next = ST_WRITE;
      ST_WRITE: begin
        bus.rf_write_enable = 1'b1;
        bus.done            = 1'b1;
        w_state_next        = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr   <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (r_state == ST_IDLE && bus.instr_valid) r_instr <= bus.instr;
      if (r_state == ST_IDLE && w_state_next == ST_READ_RS) r_rd_addr <= f_rs(bus.instr);
      if (r_state == ST_READ_RS) begin
        r_op_b <= bus.rf_read_data;
        if (w_state_next == ST_READ_RD) r_rd_addr <= f_rd(r_instr);
      end
      if (r_state == ST_READ_RD) r_op_a <= bus.rf_read_data;
      // Write port is level-sensitive: load only on the edge entering WRITE.
      if (w_state_next == ST_WRITE && r_state != ST_WRITE) begin
        r_wr_addr <= f_rd(w_cur_instr);
        r_wr_data <= w_result;
      end
    end
  end

  assign bus.rf_read_address  = r_rd_addr;
  assign bus.rf_write_address = r_wr_addr;
  assign bus.rf_write_data    = r_wr_data;

`ifdef EXEC_SEQ_FLAGS_EN
  logic r_zero;
  logic r_carry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (r_state == ST_WRITE) begin
      r_zero  <= w_zero;
      r_carry <= w_carry;
    end
  end

  assign bus.flag_zero  = r_zero;
  assign bus.flag_carry = r_carry;
`else
  logic w_unused_flags;
  assign w_unused_flags = w_zero ^ w_carry;
  assign bus.flag_zero  = 1'b0;
  assign bus.flag_carry = 1'b0;
`endif
endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: a driver pushes reference-model
// expectations at each handshake, a monitor checks every cycle and write-back.
module tb_exec_sequencer;
  import exec_seq_pkg::*;

`ifdef EXEC_SEQ_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] ins;
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] data;
    logic       z;
    logic       c;
    int         lat;
  } exp_t;

  logic clk;
  logic reset_n;
  logic preload;
  logic [7:0] rf [4];
  logic [7:0] init_vals [4];
  int   ref_regs [4];
  exp_t exp_q [$];
  bit   acc_evt;
  logic mf_z, mf_c;
  int   errors, checks;

  exec_sequencer_if #(.DATA_WIDTH(8)) bus ();

  exec_sequencer #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rf_read_data = rf[bus.rf_read_address];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4; i++) rf[i] <= init_vals[i];
    end else if (bus.rf_write_enable) begin
      rf[bus.rf_write_address] <= bus.rf_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: operand values from the model's own register array.
  task automatic model_push(input logic [7:0] ins);
    exp_t e;
    int a, b, r;
    e.ins = ins;
    e.op  = ins[7:6];
    e.rd  = ins[5:4];
    e.rs  = ins[3:2];
    a = ref_regs[e.rd];
    b = ref_regs[e.rs];
    case (e.op)
      2'd0:    begin r = int'(ins[3:0]); e.c = 1'b0; e.lat = 1; end
      2'd1:    begin r = b; e.c = 1'b0; e.lat = 2; end
      2'd2:    begin r = (a + b) % 256; e.c = ((a + b) > 255); e.lat = 3; end
      default: begin r = (a - b + 256) % 256; e.c = (a < b); e.lat = 3; end
    endcase
    e.data = 8'(r);
    e.z    = (r == 0);
    ref_regs[e.rd] = r;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] ins);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr %0h never accepted, ready=%b required 1", ins, bus.instr_ready);
    end else begin
      model_push(ins);
      acc_evt = 1'b1;
    end
  endtask

  initial begin : monitor
    int   n;
    bit   busy;
    int   txn;
    exp_t e;
    n = 0; busy = 0; txn = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        busy = 0; n = 0; mf_z = 1'b0; mf_c = 1'b0; acc_evt = 1'b0;
      end else begin
        if (acc_evt) begin
          acc_evt = 1'b0; busy = 1; n = 1;
        end else if (busy) begin
          n++;
        end
        chk("instr_ready", bus.instr_ready, !busy);
        chk("done_vs_we", bus.done, bus.rf_write_enable);
        chk("flag_zero", bus.flag_zero, mf_z);
        chk("flag_carry", bus.flag_carry, mf_c);
        if (busy && exp_q.size() > 0) begin
          if (n == 1 && exp_q[0].op != 2'd0) chk("read_addr_rs", bus.rf_read_address, exp_q[0].rs);
          if (n == 2 && exp_q[0].op[1])      chk("read_addr_rd", bus.rf_read_address, exp_q[0].rd);
        end
        if (bus.rf_write_enable) begin
          if (!busy || exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: we=1 to r%0d data %0h, required no write",
                     bus.rf_write_address, bus.rf_write_data);
          end else begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d: instr=%02h -> r%0d=%02h lat=%0d (exp r%0d=%02h lat=%0d z=%b c=%b)",
                     txn, e.ins, bus.rf_write_address, bus.rf_write_data, n, e.rd, e.data, e.lat, e.z, e.c);
            chk("latency", n, e.lat);
            chk("wr_addr", bus.rf_write_address, e.rd);
            chk("wr_data", bus.rf_write_data, e.data);
            mf_z = FLAGS_EN ? e.z : 1'b0;
            mf_c = FLAGS_EN ? e.c : 1'b0;
          end
          busy = 0;
        end else if (busy && n > 3) begin
          checks++; errors++;
          $display("FAIL write_timeout: no write-back after %0d cycles, required one", n);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          busy = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0] dir [8];
    logic [7:0] ins;
    errors = 0; checks = 0; acc_evt = 1'b0; mf_z = 1'b0; mf_c = 1'b0;
    init_vals[0] = 8'hF0; init_vals[1] = 8'h20; init_vals[2] = 8'h03; init_vals[3] = 8'h05;
    for (int i = 0; i < 4; i++) ref_regs[i] = int'(init_vals[i]);
    // ADD r0,r1; SUB r2,r3; SUB r2,r2; LDI r2,#A; LDI r1,#5; LDI r3,#7; MOV r1,r3; LDI r0,#0
    dir[0] = 8'h84; dir[1] = 8'hEC; dir[2] = 8'hE8; dir[3] = 8'h2A;
    dir[4] = 8'h15; dir[5] = 8'h37; dir[6] = 8'h5C; dir[7] = 8'h00;

    reset_n = 1'b0; preload = 1'b1; bus.instr = 8'h00; bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1'b1);
    chk("rst_we", bus.rf_write_enable, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_zero", bus.flag_zero, 1'b0);
    chk("rst_carry", bus.flag_carry, 1'b0);
    chk("rst_raddr", bus.rf_read_address, 2'd0);
    chk("rst_waddr", bus.rf_write_address, 2'd0);
    chk("rst_wdata", bus.rf_write_data, 8'h00);
    preload = 1'b0;
    reset_n = 1'b1;

    for (int k = 0; k < 8; k++) send(dir[k]);

    for (int k = 0; k < 200; k++) begin
      ins = 8'($urandom);
      send(ins);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.instr_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    // Abandon an ADD while it sits in READ_RD.
    send(8'h10);
    send(8'hB0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    bus.instr_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_ready", bus.instr_ready, 1'b1);
    chk("abort_we", bus.rf_write_enable, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_zero", bus.flag_zero, 1'b0);
    chk("abort_carry", bus.flag_carry, 1'b0);
    chk("abort_raddr", bus.rf_read_address, 2'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_ready", bus.instr_ready, 1'b1);
    chk("abort_hold_we", bus.rf_write_enable, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      ins = 8'($urandom);
      send(ins);
    end

    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) chk("rf_final", rf[i], 8'(ref_regs[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
